// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router widths and merged flit layout
//
// Purpose: widths of the router input-port datapath and the packed layout of
//          the merged {data, dst_addr} word produced by merge_addr_data.
// Ports:   none (package).
package router_pkg;

   localparam int DATA_WIDTH     = 1024;
   localparam int ADDR_WIDTH     = 10;
   localparam int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH;

   // dst_addr occupies the LSBs of the merged word.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ADDR_WIDTH-1:0] dst_addr;
   } dfx_flit_t;

endpackage

// File: rtl/dfx_send_fifo_if.sv
// rtl/dfx_send_fifo_if.sv - upstream/downstream handshake bundle of dfx_send_fifo
//
// Purpose: groups the merged-word input handshake and the split head-word
//          output handshake of the send FIFO.
// Signals: data_dfx_send/dfx_valid_in/dfx_ready_out - upstream merged word
//          data_out/dst_addr_out/valid_out/ready_in  - downstream head word
// Modports: slave  - the FIFO
//           master - the environment driving the FIFO
interface dfx_send_fifo_if;
   import router_pkg::*;

   logic [DATA_DFX_WIDTH-1:0] data_dfx_send;
   logic                      dfx_valid_in;
   logic                      dfx_ready_out;
   logic [DATA_WIDTH-1:0]     data_out;
   logic [ADDR_WIDTH-1:0]     dst_addr_out;
   logic                      valid_out;
   logic                      ready_in;

   modport slave (
      input  data_dfx_send, dfx_valid_in, ready_in,
      output dfx_ready_out, data_out, dst_addr_out, valid_out
   );

   modport master (
      output data_dfx_send, dfx_valid_in, ready_in,
      input  dfx_ready_out, data_out, dst_addr_out, valid_out
   );

endinterface

// File: rtl/dfx_fifo_ptr_ctrl.sv
// rtl/dfx_fifo_ptr_ctrl.sv - read/write pointers and status flags of the send FIFO
//
// Purpose: owns the wrap-bit pointers; derives push/pop qualifiers, occupancy
//          and full/empty/almost_full from the registered pointers.
// Ports:   clk, rst_n           - clock, async active-low reset
//          push_req, pop_req    - upstream valid, downstream ready
//          push, pop            - qualified handshakes
//          wr_idx, rd_idx       - memory indices (pointer low bits)
//          count                - occupancy
//          full, empty, almost_full - status flags
module dfx_fifo_ptr_ctrl #(
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_req,
   input  logic                       pop_req,
   output logic                       push,
   output logic                       pop,
   output logic [$clog2(DEPTH)-1:0]   wr_idx,
   output logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Qualifiers depend only on registered flags, so ready never depends
   // combinationally on the downstream ready.
   assign push = push_req && !full;
   assign pop  = pop_req && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign wr_idx      = wr_ptr[IW-1:0];
   assign rd_idx      = rd_ptr[IW-1:0];
   // Extra MSB distinguishes a full ring from an empty one.
   assign full        = (wr_ptr[IW] != rd_ptr[IW]) && (wr_idx == rd_idx);
   assign empty       = (wr_ptr == rd_ptr);
   assign count       = CW'(wr_ptr - rd_ptr);
   assign almost_full = (count >= CW'(AF_THRESH));

endmodule

// File: rtl/dfx_send_fifo.sv
// rtl/dfx_send_fifo.sv - first-word-fall-through elastic buffer for merged dfx words
//
// Purpose: buffers {data, dst_addr} words from merge_addr_data and presents the
//          head word with dst_addr split out for route lookup.
// Ports:   clk, rst_n  - clock, async active-low reset
//          bus (slave) - data_dfx_send/dfx_valid_in/dfx_ready_out in,
//                        data_out/dst_addr_out/valid_out/ready_in out
//          count, full, empty, almost_full - occupancy and status
//          pkt_count, overflow_attempt     - only with DFX_FIFO_STATS_EN
// Option:  DFX_FIFO_STATS_EN adds the accepted-push counter and the sticky
//          push-while-full flag.
module dfx_send_fifo
   import router_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   dfx_send_fifo_if.slave             bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full
`ifdef DFX_FIFO_STATS_EN
   ,
   output logic [31:0]                pkt_count,
   output logic                       overflow_attempt
`endif
);

   localparam int IW = $clog2(DEPTH);

   logic          push;
   logic          pop;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;
   dfx_flit_t     mem [DEPTH];
   dfx_flit_t     head;

   dfx_fifo_ptr_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) u_ptr_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_req    (bus.dfx_valid_in),
      .pop_req     (bus.ready_in),
      .push        (push),
      .pop         (pop),
      .wr_idx      (wr_idx),
      .rd_idx      (rd_idx),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
   );

   // Storage is intentionally not reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= dfx_flit_t'(bus.data_dfx_send);
   end

   // Head is driven straight from memory even when empty (no X gating).
   assign head              = mem[rd_idx];
   assign bus.data_out      = head.data;
   assign bus.dst_addr_out  = head.dst_addr;
   assign bus.valid_out     = !empty;
   assign bus.dfx_ready_out = !full;

`ifdef DFX_FIFO_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count        <= '0;
         overflow_attempt <= 1'b0;
      end else begin
         if (push && (pkt_count != 32'hFFFF_FFFF)) pkt_count <= pkt_count + 32'd1;
         if (bus.dfx_valid_in && full) overflow_attempt <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dfx_send_fifo.sv
// tb/tb_dfx_send_fifo.sv - scoreboard bench for dfx_send_fifo
module tb_dfx_send_fifo;
   import router_pkg::*;

   localparam int DEPTH = 4;
   localparam int AF    = DEPTH - 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          almost_full;
`ifdef DFX_FIFO_STATS_EN
   logic [31:0]   pkt_count;
   logic          overflow_attempt;
`endif

   dfx_send_fifo_if bus ();

   dfx_send_fifo #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
`ifdef DFX_FIFO_STATS_EN
      ,
      .pkt_count        (pkt_count),
      .overflow_attempt (overflow_attempt)
`endif
   );

   always #5 clk = ~clk;

   int        n_checks = 0;
   int        n_pass   = 0;
   dfx_flit_t sb_q[$];
   int        mcnt     = 0;
   bit        acc_push = 1'b0;
   longint unsigned m_pkt = 0;
   bit        m_ovf    = 1'b0;
   dfx_flit_t mon_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic dfx_flit_t mk(input logic [DATA_WIDTH-1:0] d, input logic [ADDR_WIDTH-1:0] a);
      dfx_flit_t f;
      f.data     = d;
      f.dst_addr = a;
      return f;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rnd_data();
      logic [DATA_WIDTH-1:0] d;
      for (int i = 0; i < DATA_WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Reference model: a queue of accepted words plus an occupancy count.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt     = 0;
         sb_q.delete();
         acc_push = 1'b0;
         m_pkt    = 0;
         m_ovf    = 1'b0;
      end else begin
         acc_push = bus.dfx_valid_in && (mcnt < DEPTH);
         if (bus.dfx_valid_in && (mcnt == DEPTH)) m_ovf = 1'b1;
         if (bus.ready_in && (mcnt > 0)) mcnt--;
         if (acc_push) begin
            sb_q.push_back(dfx_flit_t'(bus.data_dfx_send));
            mcnt++;
            if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
         end
      end
   end

   // Monitor: samples mid-low-phase, compares flags and the head word, and
   // retires the head when the downstream accepts it.
   always @(negedge clk) begin
      #1;
      chk("count", 64'(count), 64'(mcnt));
      chk("empty", 64'(empty), 64'(mcnt == 0));
      chk("full", 64'(full), 64'(mcnt == DEPTH));
      chk("almost_full", 64'(almost_full), 64'(mcnt >= AF));
      chk("dfx_ready_out", 64'(bus.dfx_ready_out), 64'(mcnt < DEPTH));
      chk("valid_out", 64'(bus.valid_out), 64'(mcnt != 0));
`ifdef DFX_FIFO_STATS_EN
      chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
      chk("overflow_attempt", 64'(overflow_attempt), 64'(m_ovf));
`endif
      if (mcnt > 0 && sb_q.size() > 0) begin
         mon_exp = sb_q[0];
         n_checks++;
         if (bus.data_out === mon_exp.data) n_pass++;
         else $display("FAIL data_out: got low 0x%h expected low 0x%h",
                       bus.data_out[127:0], mon_exp.data[127:0]);
         chk("dst_addr_out", 64'(bus.dst_addr_out), 64'(mon_exp.dst_addr));
         if (bus.ready_in) void'(sb_q.pop_front());
      end
   end

   task automatic step(input bit v, input dfx_flit_t w, input bit r);
      @(negedge clk);
      bus.dfx_valid_in  = v;
      bus.data_dfx_send = w;
      bus.ready_in      = r;
   endtask

   task automatic push_word(input dfx_flit_t w, input bit r);
      step(1'b1, w, r);
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         if (acc_push) return;
      end
      n_checks++;
      $display("FAIL push_timeout: word addr 0x%0h not accepted within 32 cycles", w.dst_addr);
   endtask

   task automatic idle(input int n, input bit r);
      repeat (n) step(1'b0, '0, r);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n            = 1'b0;
      bus.dfx_valid_in = 1'b0;
      bus.ready_in     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_WIDTH-1:0] a5;
      bit                    v;

      bus.dfx_valid_in  = 1'b0;
      bus.ready_in      = 1'b0;
      bus.data_dfx_send = '0;
      a5 = {(DATA_WIDTH / 8){8'hA5}};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single word, held at the head.
      push_word(mk(a5, 10'h2AA), 1'b0);
      idle(2, 1'b0);

      // Fill to full, then push attempts while full.
      for (int i = 1; i < DEPTH; i++) push_word(mk(rnd_data(), ADDR_WIDTH'(i)), 1'b0);
      repeat (3) step(1'b1, mk(rnd_data(), 10'h3FF), 1'b0);
      idle(DEPTH + 2, 1'b1);

      // Simultaneous push/pop at count 2.
      push_word(mk(rnd_data(), 10'd0), 1'b0);
      push_word(mk(rnd_data(), 10'd1), 1'b0);
      push_word(mk(rnd_data(), 10'd2), 1'b1);
      push_word(mk(rnd_data(), 10'd3), 1'b1);
      idle(DEPTH + 2, 1'b1);

      // Ten words with ready toggling.
      for (int i = 0; i < 10; i++) push_word(mk(rnd_data(), ADDR_WIDTH'(i)), i[0]);
      idle(DEPTH + 2, 1'b1);

      // Random traffic; the driver holds a word until the model accepts it.
      for (int i = 0; i < 400; i++) begin
         if (!bus.dfx_valid_in || acc_push) begin
            v = ($urandom_range(0, 99) < 60);
            step(v, mk(rnd_data(), ADDR_WIDTH'($urandom)), ($urandom_range(0, 99) < 50));
         end else begin
            step(1'b1, dfx_flit_t'(bus.data_dfx_send), ($urandom_range(0, 99) < 50));
         end
      end
      idle(DEPTH + 2, 1'b1);

      // Reset at count 3.
      for (int i = 0; i < 3; i++) push_word(mk(rnd_data(), ADDR_WIDTH'(i + 5)), 1'b0);
      pulse_reset();
      idle(2, 1'b0);

      // Push while full, then reset.
      for (int i = 0; i < DEPTH; i++) push_word(mk(rnd_data(), ADDR_WIDTH'(i + 9)), 1'b0);
      repeat (2) step(1'b1, mk(rnd_data(), 10'h155), 1'b0);
      idle(1, 1'b0);
      pulse_reset();
      idle(2, 1'b0);

      // Short post-reset sanity run.
      for (int i = 0; i < 6; i++) push_word(mk(rnd_data(), ADDR_WIDTH'(i + 20)), 1'b1);
      idle(DEPTH + 2, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dfx_send_fifo.md
# dfx_send_fifo

Elastic buffer directly downstream of `merge_addr_data` in the router input port. Accepts merged `{data, dst_addr}` words (`data_dfx_send`) with a valid/ready handshake and stores them in a DEPTH-entry first-word-fall-through FIFO. Presents the head word to the crossbar/output-port stage with `dst_addr` split back out for route lookup. Decouples the arbiter from downstream back-pressure.

## Interface
- `DATA_WIDTH`, 1024, payload width
- `ADDR_WIDTH`, 10, destination address width
- `DATA_DFX_WIDTH`, DATA_WIDTH+ADDR_WIDTH, merged word width (derived; not overridden)
- `DEPTH`, 4, entries; power of two, ≥2
- `AF_THRESH`, DEPTH-1, almost-full asserts when count ≥ AF_THRESH
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `data_dfx_send`  in  DATA_DFX_WIDTH  merged word; `[ADDR_WIDTH-1:0]` = dst_addr, upper bits = data
- `dfx_valid_in`  in  1  upstream word valid
- `dfx_ready_out`  out  1  FIFO can accept (= !full)
- `data_out`  out  DATA_WIDTH  head-word payload
- `dst_addr_out`  out  ADDR_WIDTH  head-word destination address
- `valid_out`  out  1  head word valid (= !empty)
- `ready_in`  in  1  downstream accepts head word
- `count`  out  $clog2(DEPTH+1)  occupancy
- `full`, `empty`, `almost_full`  out  1 each  status flags

## Operation
- Push when `dfx_valid_in && dfx_ready_out`: write `mem[wr_ptr]`, increment `wr_ptr`.
- Pop when `valid_out && ready_in`: increment `rd_ptr`.
- Pointers are $clog2(DEPTH)+1 bits; index = low bits; wrap naturally modulo 2·DEPTH. full = MSBs differ and index bits equal; empty = pointers equal.
- `count` = wr_ptr − rd_ptr (modulo arithmetic, width as declared).
- Push and pop in the same cycle: both take effect, count unchanged.
- Full: `dfx_ready_out`=0; a same-cycle pop does NOT enable a push (ready is not combinationally dependent on `ready_in`).
- Empty: `valid_out`=0; `data_out`/`dst_addr_out` are don't-care but driven from `mem[rd_ptr]` (no X gating).
- `dfx_valid_in` asserted while not ready: no write, no state change; upstream must hold the word.
- Downstream must not see `valid_out` drop without a pop; it deasserts only when the last word is popped.
- Data is stored unmodified; the split is pure bit-selection of the stored word.

## Timing
- Reset (async assert, sync-safe release): pointers 0, count 0, `empty`=1, `full`=0, `almost_full`=0, `valid_out`=0, `dfx_ready_out`=1. Memory not reset.
- Push-to-output latency: word pushed at edge N appears on `data_out`/`valid_out` after edge N (visible in cycle N+1) when FIFO was empty.
- Flags and `count` are functions of registered pointers: update one cycle after the causing handshake edge.
- Reset mid-operation: all contents discarded, outputs return to reset values immediately.
- Sustained throughput: one push and one pop per cycle when neither full nor empty.

## Configuration
- `DFX_FIFO_STATS_EN` defined: adds output `pkt_count` (32 bits), a saturating counter of accepted pushes, reset to 0, holds at 32'hFFFF_FFFF; plus output `overflow_attempt` (1 bit), sticky flag set when `dfx_valid_in` is high while `full`, cleared only by reset.
- Undefined: neither port nor its logic exists; behaviour otherwise identical.

## Structure
- Shared package `router_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, `DATA_DFX_WIDTH` defaults and a packed struct `dfx_flit_t` {data, dst_addr} matching the merged word layout (dst_addr in LSBs), reused by `merge_addr_data` and this block.
- One natural sub-module: `dfx_fifo_ptr_ctrl` (pointer registers, full/empty/almost_full/count); memory array and output split stay in the top.

## Test plan
- Reset: hold rst_n=0 three cycles → empty=1, full=0, count=0, valid_out=0, dfx_ready_out=1.
- Single word: push data=1024'hA5…A5, dst_addr=10'h2AA with ready_in=0 → next cycle valid_out=1, data_out=A5…A5, dst_addr_out=10'h2AA, count=1.
- Fill: 4 pushes (DEPTH=4), ready_in=0 → count=4, full=1, almost_full=1 from count=3, dfx_ready_out=0; 5th valid word not written, first-in still at head.
- Simultaneous: at count=2 push and pop in same cycle → count stays 2, order preserved (sequence 0,1,2,3 read back in order).
- Wrap: 10 words streamed with ready_in toggling 1/0 → all 10 emerge in order, addresses 0..9 intact, no loss.
- Reset mid-stream: rst_n=0 at count=3 → count=0, valid_out=0 same cycle; with `DFX_FIFO_STATS_EN`, pkt_count=0 and overflow_attempt=0 after push-while-full then reset.
